// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-format encodings, receiver FSM states and divisor helpers.
// Used by both the configurable receiver and the configurable transmitter.
package uart_pkg;

    localparam int unsigned MIN_DIV_DEFAULT = 8;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b10;
    localparam logic [1:0] STOP_2   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_DONE
    } uart_rx_state_e;

    // 11 is treated as "no parity", same as 00.
    function automatic logic parity_enabled(input logic [1:0] par);
        return (par == PAR_ODD) || (par == PAR_EVEN);
    endfunction

    // 1.5 stop bits is received as a single checked stop bit.
    function automatic logic two_stop_bits(input logic [1:0] sb);
        return sb == STOP_2;
    endfunction

    function automatic logic [31:0] clamp_div(input logic [31:0] bps, input int unsigned min_div);
        return (bps < 32'(min_div)) ? 32'(min_div) : bps;
    endfunction

endpackage

// File: rtl/uart_rx_baud.sv
// Runtime-divisor bit counter with a mid-bit decision strobe for the UART receiver.
// With UART_RX_MAJORITY_EN defined the strobe moves from half-1 to half so the last of three samples is in.
module uart_rx_baud
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [31:0] div,
    output logic        strobe
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] half;
    logic [31:0] strobe_pt;

    assign half = div >> 1;

`ifdef UART_RX_MAJORITY_EN
    assign strobe_pt = half;
`else
    assign strobe_pt = half - 32'd1;
`endif

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (clr || (cnt_q == div - 32'd1)) begin
            cnt_d = 32'd0;
        end
    end

    assign strobe = (cnt_q == strobe_pt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: programmable divisor, parity and stop bits, one byte per frame.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions around mid-bit.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_DIV     = MIN_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bps_para,
    input  logic [1:0]  parity,
    input  logic [1:0]  stopbit,
    input  logic        rs422_rx,
    output logic [7:0]  rx_data,
    output logic        valid,
    output logic        check,
    output logic        stop,
    output logic        busy
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_prev_q, rx_prev_d;
    logic                   rx_s;
    logic                   fall;
    logic                   bit_val;

    uart_rx_state_e state_q, state_d;
    logic [31:0]    div_q, div_d;
    logic [1:0]     par_q, par_d;
    logic [1:0]     stop_cfg_q, stop_cfg_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           perr_q, perr_d;
    logic           serr_q, serr_d;
    logic           serr_new;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           valid_q, valid_d;
    logic           check_q, check_d;
    logic           stop_q, stop_d;
    logic           busy_q, busy_d;

    logic           baud_clr;
    logic           strobe;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], rs422_rx};
    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign rx_prev_d = rx_s;
    assign fall      = rx_prev_q & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] holds rx_s from counter value half-1, hist_q[1] from half-2.
    logic [1:0] hist_q, hist_d;
    assign hist_d  = {hist_q[0], rx_s};
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign serr_new = serr_q | ~bit_val;

    uart_rx_baud u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (baud_clr),
        .div    (div_q),
        .strobe (strobe)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        par_d      = par_q;
        stop_cfg_d = stop_cfg_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        serr_d     = serr_q;
        rx_data_d  = rx_data_q;
        valid_d    = 1'b0;
        check_d    = 1'b0;
        stop_d     = 1'b0;
        busy_d     = busy_q;
        baud_clr   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                baud_clr = 1'b1;
                if (fall) begin
                    state_d    = ST_START;
                    div_d      = clamp_div(bps_para, MIN_DIV);
                    par_d      = parity;
                    stop_cfg_d = stopbit;
                    bit_idx_d  = 3'd0;
                    perr_d     = 1'b0;
                    serr_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_START: begin
                if (strobe) begin
                    if (bit_val) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (strobe) begin
                    shift_d   = {bit_val, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = parity_enabled(par_q) ? ST_PARITY : ST_STOP1;
                    end
                end
            end
            ST_PARITY: begin
                if (strobe) begin
                    if (par_q == PAR_ODD) begin
                        perr_d = ~(^shift_q ^ bit_val);
                    end else begin
                        perr_d = ^shift_q ^ bit_val;
                    end
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (strobe) begin
                    serr_d = serr_new;
                    if (two_stop_bits(stop_cfg_q)) begin
                        state_d = ST_STOP2;
                    end else begin
                        state_d   = ST_DONE;
                        valid_d   = 1'b1;
                        rx_data_d = shift_q;
                        check_d   = perr_q;
                        stop_d    = serr_new;
                    end
                end
            end
            ST_STOP2: begin
                if (strobe) begin
                    serr_d    = serr_new;
                    state_d   = ST_DONE;
                    valid_d   = 1'b1;
                    rx_data_d = shift_q;
                    check_d   = perr_q;
                    stop_d    = serr_new;
                end
            end
            ST_DONE: begin
                // Edges seen here are dropped: rx_prev already tracks the line.
                baud_clr = 1'b1;
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= {SYNC_STAGES{1'b1}};
            rx_prev_q  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            hist_q     <= 2'b11;
`endif
            state_q    <= ST_IDLE;
            div_q      <= 32'(MIN_DIV);
            par_q      <= PAR_NONE;
            stop_cfg_q <= STOP_1;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            rx_data_q  <= 8'd0;
            valid_q    <= 1'b0;
            check_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rx_prev_q  <= rx_prev_d;
`ifdef UART_RX_MAJORITY_EN
            hist_q     <= hist_d;
`endif
            state_q    <= state_d;
            div_q      <= div_d;
            par_q      <= par_d;
            stop_cfg_q <= stop_cfg_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            rx_data_q  <= rx_data_d;
            valid_q    <= valid_d;
            check_q    <= check_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_data = rx_data_q;
    assign valid   = valid_q;
    assign check   = check_q;
    assign stop    = stop_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: table-driven frames, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_cfg;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bps_para = 32'd104;
    logic [1:0]  parity = 2'b00;
    logic [1:0]  stopbit = 2'b00;
    logic        rs422_rx = 1'b1;
    logic [7:0]  rx_data;
    logic        valid;
    logic        check;
    logic        stop;
    logic        busy;

    uart_rx_cfg #(.SYNC_STAGES(SYNC), .MIN_DIV(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bps_para (bps_para),
        .parity   (parity),
        .stopbit  (stopbit),
        .rs422_rx (rs422_rx),
        .rx_data  (rx_data),
        .valid    (valid),
        .check    (check),
        .stop     (stop),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       s;
        int         t;
    } ev_t;

    ev_t  evq[$];
    int   busy_rises = 0;
    logic busy_prev = 1'b0;
    int   qual_err = 0;

    always @(negedge clk) begin
        ev_t e;
        if (valid === 1'b1) begin
            e.d = rx_data;
            e.c = check;
            e.s = stop;
            e.t = cyc;
            evq.push_back(e);
        end
        if (valid !== 1'b1 && (check !== 1'b0 || stop !== 1'b0)) qual_err++;
        if (busy === 1'b1 && busy_prev !== 1'b1) busy_rises++;
        busy_prev = busy;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        rs422_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Parity bit the transmitter puts on the wire so the total count of ones matches the mode.
    function automatic logic wire_parity(input logic [7:0] d, input logic [1:0] par);
        int ones;
        ones = $countones(d);
        if (par == 2'b01) return (ones % 2) == 0;
        return (ones % 2) == 1;
    endfunction

    function automatic logic ref_parity_err(input logic [7:0] d, input logic [1:0] par, input logic pw);
        int ones;
        ones = $countones(d) + int'(pw);
        if (par == 2'b01) return (ones % 2) == 0;
        if (par == 2'b10) return (ones % 2) == 1;
        return 1'b0;
    endfunction

    // Drives one frame; t0 is the cycle the start bit begins, nlast the index of the final stop bit.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] par, input logic [1:0] sb,
                              input int bitclk, input bit bad_par, input bit bad_stop,
                              input bit bad_stop2, input bit hold_low,
                              output int t0, output int nlast);
        logic pw;
        t0 = cyc;
        nlast = 9;
        drive(1'b0, bitclk);
        for (int i = 0; i < 8; i++) drive(d[i], bitclk);
        if (par == 2'b01 || par == 2'b10) begin
            pw = wire_parity(d, par) ^ bad_par;
            drive(pw, bitclk);
            nlast++;
        end
        drive(~bad_stop, bitclk);
        if (sb == 2'b11) begin
            drive(~bad_stop2, bitclk);
            nlast++;
        end
        rs422_rx = hold_low ? 1'b0 : 1'b1;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] ed, input logic ec, input logic es,
                                input int t0, input int nlast, input int bitclk);
        ev_t e;
        int lo;
        int hi;
        cmp({name, "_present"}, 32'(evq.size() > 0), 32'd1);
        if (evq.size() == 0) return;
        e = evq.pop_front();
        lo = t0 + nlast * bitclk + bitclk / 2;
        hi = lo + SYNC + 4;
        cmp({name, "_data"}, 32'(e.d), 32'(ed));
        cmp({name, "_check"}, 32'(e.c), 32'(ec));
        cmp({name, "_stop"}, 32'(e.s), 32'(es));
        cmp({name, "_latency"}, 32'(e.t >= lo && e.t <= hi), 32'd1);
        $display("frame %s: data=%02h check=%0b stop=%0b valid at +%0d (centre of last stop +%0d)",
                 name, e.d, e.c, e.s, e.t - t0, e.t - lo);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  par;
        logic [1:0]  sb;
        logic [31:0] bps;
        int          bitclk;
        bit          bad_par;
        bit          bad_stop;
        logic [7:0]  exp_d;
        logic        exp_c;
        logic        exp_s;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nl;
        int br;
        logic [7:0] d;
        logic [1:0] par;
        logic [1:0] sb;
        int bitclk;
        bit bp;
        bit bs;
        bit bs2;
        logic pw;
        logic ec;
        logic es;

        tbl[0] = '{8'hA5, 2'b00, 2'b00, 32'd104, 104, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 2'b01, 2'b11, 32'd104, 104, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
        tbl[2] = '{8'h3C, 2'b01, 2'b11, 32'd104, 104, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
        tbl[3] = '{8'h55, 2'b00, 2'b00, 32'd104, 104, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
        tbl[4] = '{8'h96, 2'b10, 2'b01, 32'd16,  16,  1'b0, 1'b0, 8'h96, 1'b0, 1'b0};
        tbl[5] = '{8'h0F, 2'b10, 2'b10, 32'd20,  20,  1'b1, 1'b0, 8'h0F, 1'b1, 1'b0};
        tbl[6] = '{8'hFF, 2'b11, 2'b00, 32'd8,   8,   1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[7] = '{8'h00, 2'b01, 2'b11, 32'd4,   8,   1'b0, 1'b1, 8'h00, 1'b0, 1'b1};

        // Reset state
        idle(4);
        cmp("reset_rx_data", 32'(rx_data), 32'd0);
        cmp("reset_valid", 32'(valid), 32'd0);
        cmp("reset_check", 32'(check), 32'd0);
        cmp("reset_stop", 32'(stop), 32'd0);
        cmp("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle(10);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            bps_para = tbl[i].bps;
            parity   = tbl[i].par;
            stopbit  = tbl[i].sb;
            send_frame(tbl[i].d, tbl[i].par, tbl[i].sb, tbl[i].bitclk, tbl[i].bad_par,
                       tbl[i].bad_stop, 1'b0, 1'b0, t0, nl);
            idle(tbl[i].bitclk + 8);
            expect_frame($sformatf("tbl%0d", i), tbl[i].exp_d, tbl[i].exp_c, tbl[i].exp_s,
                         t0, nl, tbl[i].bitclk);
            cmp($sformatf("tbl%0d_single_valid", i), 32'(evq.size()), 32'd0);
        end

        // Framing error followed by a break: exactly one frame until a fresh edge
        bps_para = 32'd104; parity = 2'b00; stopbit = 2'b00;
        send_frame(8'h55, 2'b00, 2'b00, 104, 1'b0, 1'b1, 1'b0, 1'b1, t0, nl);
        idle(20 * 104);
        expect_frame("break", 8'h55, 1'b0, 1'b1, t0, nl, 104);
        cmp("break_no_extra", 32'(evq.size()), 32'd0);
        cmp("break_idle_busy", 32'(busy), 32'd0);
        rs422_rx = 1'b1;
        idle(300);
        cmp("break_release_no_valid", 32'(evq.size()), 32'd0);
        send_frame(8'hC3, 2'b00, 2'b00, 104, 1'b0, 1'b0, 1'b0, 1'b0, t0, nl);
        idle(112);
        expect_frame("after_break", 8'hC3, 1'b0, 1'b0, t0, nl, 104);

        // Short glitch on an idle line
        br = busy_rises;
        drive(1'b0, 10);
        drive(1'b1, 200);
        cmp("glitch_no_valid", 32'(evq.size()), 32'd0);
        cmp("glitch_busy_pulsed", 32'(busy_rises - br), 32'd1);
        cmp("glitch_busy_clear", 32'(busy), 32'd0);
        $display("glitch: busy pulses=%0d valids=%0d", busy_rises - br, evq.size());

        // Divisor clamped, then bps_para changed mid-frame
        bps_para = 32'd4;
        fork
            send_frame(8'h6B, 2'b00, 2'b00, 8, 1'b0, 1'b0, 1'b0, 1'b0, t0, nl);
            begin
                idle(30);
                bps_para = 32'd50;
            end
        join
        idle(16);
        expect_frame("bps_change", 8'h6B, 1'b0, 1'b0, t0, nl, 8);

        // Back-to-back frames with no idle gap
        bps_para = 32'd16;
        begin
            int ta;
            int na;
            send_frame(8'h12, 2'b00, 2'b00, 16, 1'b0, 1'b0, 1'b0, 1'b0, ta, na);
            send_frame(8'hED, 2'b00, 2'b00, 16, 1'b0, 1'b0, 1'b0, 1'b0, t0, nl);
            idle(24);
            expect_frame("b2b_first", 8'h12, 1'b0, 1'b0, ta, na, 16);
            expect_frame("b2b_second", 8'hED, 1'b0, 1'b0, t0, nl, 16);
        end

        // Reset in the middle of the data bits
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b0, 16);
        drive(1'b1, 8);
        cmp("midframe_busy", 32'(busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        cmp("rst_rx_data", 32'(rx_data), 32'd0);
        cmp("rst_valid", 32'(valid), 32'd0);
        cmp("rst_check", 32'(check), 32'd0);
        cmp("rst_stop", 32'(stop), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        rs422_rx = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(40);
        cmp("rst_no_partial_frame", 32'(evq.size()), 32'd0);
        send_frame(8'h81, 2'b00, 2'b00, 16, 1'b0, 1'b0, 1'b0, 1'b0, t0, nl);
        idle(24);
        expect_frame("after_rst", 8'h81, 1'b0, 1'b0, t0, nl, 16);

        // Randomized frames against the reference model
        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom);
            par = 2'($urandom_range(0, 3));
            sb  = 2'($urandom_range(0, 3));
            bitclk = $urandom_range(8, 40);
            if ($urandom_range(0, 5) == 0) begin
                bps_para = 32'($urandom_range(0, 7));
                bitclk = 8;
            end else begin
                bps_para = 32'(bitclk);
            end
            parity  = par;
            stopbit = sb;
            bp  = ($urandom_range(0, 3) == 0);
            bs  = ($urandom_range(0, 3) == 0);
            bs2 = ($urandom_range(0, 3) == 0);
            pw  = wire_parity(d, par) ^ bp;
            ec  = ref_parity_err(d, par, pw);
            es  = bs || (sb == 2'b11 && bs2);
            send_frame(d, par, sb, bitclk, bp, bs, bs2, 1'b0, t0, nl);
            idle(bitclk + $urandom_range(8, 20));
            expect_frame($sformatf("rnd%0d", k), d, ec, es, t0, nl, bitclk);
        end

        idle(20);
        cmp("no_stray_valid", 32'(evq.size()), 32'd0);
        cmp("flags_only_with_valid", 32'(qual_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
